piezo_tone_rx: RTL

Tone receiver/decoder for the piezo drive pair: samples `piezo`/`piezo_n`, measures the square-wave period, classifies it as one of the four alert notes (G6, C7, E7, G7), and reports each completed note with its code and length in tone cycles. It sits on the bench/self-test side of the piezo interface, checking alert-tone sequences and drive-pair integrity without an external scope.

---
 rtl/piezo_tone_rx.sv | 108 ++++++++++
 1 files changed

// File: rtl/piezo_tone_rx.sv
// piezo_tone_rx: measures the rising-edge period of the piezo drive, classifies
// it as one of four alert notes and reports each finished note with its length.
module piezo_tone_rx #(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        piezo,
    input  logic        piezo_n,
    input  logic        err_clr,
    output logic [2:0]  cur_note,
    output logic        note_vld,
    output logic [2:0]  note_code,
    output logic [15:0] note_cyc,
    output logic        diff_err
);
    localparam int DIV = FAST_SIM ? 512 : 1;
    localparam int NP1 = 31888 / DIV;
    localparam int NP2 = 23890 / DIV;
    localparam int NP3 = 18961 / DIV;
    localparam int NP4 = 15944 / DIV;
    localparam logic [16:0] TIMEOUT = 17'(2 * NP1);

    typedef enum logic [1:0] {SILENT, ARM, CONFIRM, TONE} state_t;

    state_t      state;
    logic [1:0]  s_p, s_n;
    logic        prev_p, rise, tmo;
    logic [16:0] per_cnt;
    logic [2:0]  cls, cand;
    logic [15:0] cyc_cnt;

    function automatic logic in_win(input logic [16:0] p, input int np);
        int d;
        d = int'(p) - np;
        return (d <= (np >>> 4)) && (d >= -(np >>> 4));
    endfunction

    always_comb begin
        rise = s_p[1] & ~prev_p;
        tmo  = per_cnt == TIMEOUT;
        cls  = in_win(per_cnt, NP1) ? 3'd1 :
               in_win(per_cnt, NP2) ? 3'd2 :
               in_win(per_cnt, NP3) ? 3'd3 :
               in_win(per_cnt, NP4) ? 3'd4 : 3'd0;
    end

    // piezo_n synchronizer idles at 1 so a healthy idle pair does not flag diff_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_p       <= 2'b00;
            s_n       <= 2'b11;
            prev_p    <= 1'b0;
            per_cnt   <= '0;
            state     <= SILENT;
            cand      <= '0;
            cyc_cnt   <= '0;
            cur_note  <= '0;
            note_vld  <= 1'b0;
            note_code <= '0;
            note_cyc  <= '0;
            diff_err  <= 1'b0;
        end else begin
            s_p      <= {s_p[0], piezo};
            s_n      <= {s_n[0], piezo_n};
            prev_p   <= s_p[1];
            per_cnt  <= rise ? 17'd1 : (tmo ? per_cnt : per_cnt + 17'd1);
            diff_err <= (s_p[1] == s_n[1]) ? 1'b1 : (err_clr ? 1'b0 : diff_err);
            note_vld <= 1'b0;
            case (state)
                SILENT: if (rise) state <= ARM;
                ARM: begin
                    if (rise && cls != 3'd0) begin
                        state   <= CONFIRM;
                        cand    <= cls;
                        cyc_cnt <= 16'd1;
                    end else if (!rise && tmo) state <= SILENT;
                end
                CONFIRM: begin
                    if (rise) begin
                        if (cls == cand) begin
                            state    <= TONE;
                            cur_note <= cand;
                            cyc_cnt  <= 16'd2;
                        end else if (cls != 3'd0) begin
                            cand    <= cls;
                            cyc_cnt <= 16'd1;
                        end else state <= ARM;
                    end else if (tmo) state <= SILENT;
                end
                TONE: begin
                    if (rise && cls == cur_note) begin
                        cyc_cnt <= (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
                    end else if (rise || tmo) begin
                        note_vld  <= 1'b1;
                        note_code <= cur_note;
                        note_cyc  <= cyc_cnt;
                        cur_note  <= 3'd0;
                        cand      <= cls;
                        cyc_cnt   <= 16'd1;
                        state     <= !rise ? SILENT : (cls != 3'd0 ? CONFIRM : ARM);
                    end
                end
                default: state <= SILENT;
            endcase
        end
    end
endmodule
